// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C slave receive path.
package i2c_pkg;

    localparam int unsigned I2C_BYTE_W = 8;
    localparam int unsigned I2C_ADDR_W = 7;
    localparam int unsigned I2C_CNT_W  = 3;

    localparam logic RW_WRITE = 1'b0;
    localparam logic RW_READ  = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2,
        ST_SKIP = 2'd3
    } i2c_state_e;

    // One receive FIFO entry: first-data-byte flag plus the byte itself
    typedef struct packed {
        logic                  first;
        logic [I2C_BYTE_W-1:0] data;
    } rx_entry_t;

endpackage

// File: rtl/i2c_rx_fifo.sv
// First-word-fall-through synchronous FIFO; a push into a full FIFO is
// accepted only when a pop happens in the same cycle.
module i2c_rx_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 9
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       i_push,
    input  logic [WIDTH-1:0]           i_push_data,
    input  logic                       i_pop,
    output logic [WIDTH-1:0]           o_head,
    output logic                       o_full,
    output logic                       o_empty,
    output logic [$clog2(DEPTH):0]     o_level
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned LW = AW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [LW-1:0]    r_level;

    logic w_full;
    logic w_empty;
    logic w_do_pop;
    logic w_do_push;

    assign w_full    = (r_level == LW'(DEPTH));
    assign w_empty   = (r_level == LW'(0));
    assign w_do_pop  = i_pop && !w_empty;
    assign w_do_push = i_push && (!w_full || w_do_pop);

    // Pointers and occupancy; pointers wrap naturally since DEPTH is a power of 2
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            unique case ({w_do_push, w_do_pop})
                2'b10:   r_level <= r_level + LW'(1);
                2'b01:   r_level <= r_level - LW'(1);
                default: r_level <= r_level;
            endcase
        end
    end

    // Storage carries no reset; the head is masked while empty
    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr] <= i_push_data;
    end

    assign o_head  = w_empty ? '0 : r_mem[r_rd_ptr];
    assign o_full  = w_full;
    assign o_empty = w_empty;
    assign o_level = r_level;

endmodule

// File: rtl/i2c_rx_assembler.sv
// I2C slave receive stage: assembles reader bit strobes into bytes, matches
// the address byte and buffers write-data bytes in a FWFT FIFO.
module i2c_rx_assembler
    import i2c_pkg::*;
#(
    parameter int unsigned           FIFO_DEPTH = 4,
    parameter logic [I2C_ADDR_W-1:0] OWN_ADDR   = 7'h50
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          rd_ld,
    input  logic                          rd_bit,
    input  logic                          get_start,
    input  logic                          get_stop,
    input  logic                          bus_err,
    output logic [I2C_BYTE_W-1:0]         rx_data,
    output logic                          rx_first,
    output logic                          rx_valid,
    input  logic                          rx_ready,
    output logic                          addr_match,
    output logic                          rw_bit,
    output logic                          frame_active,
    output logic                          overflow,
    output logic                          frame_err,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

    localparam int unsigned SH_W = I2C_BYTE_W - 1;

    i2c_state_e           r_state;
    i2c_state_e           w_state_nxt;
    logic [SH_W-1:0]      r_sh;
    logic [SH_W-1:0]      w_sh_nxt;
    logic [I2C_CNT_W-1:0] r_bit_cnt;
    logic [I2C_CNT_W-1:0] w_bit_cnt_nxt;
    logic                 r_first;
    logic                 w_first_nxt;
    logic                 r_rw_bit;
    logic                 w_rw_bit_nxt;
    logic                 r_addr_match;
    logic                 w_addr_match_nxt;
    logic                 r_frame_err;
    logic                 w_frame_err_nxt;
    logic                 r_overflow;
    logic                 r_frame_active;

    logic [I2C_BYTE_W-1:0] w_byte;
    logic                  w_in_frame;
    logic                  w_mid_byte;
    logic                  w_push;
    logic                  w_pop;
    logic                  w_full;
    logic                  w_empty;
    logic                  w_drop;
    rx_entry_t             w_push_entry;
    rx_entry_t             w_head;

    assign w_byte     = {r_sh, rd_bit};
    assign w_in_frame = (r_state == ST_ADDR) || (r_state == ST_DATA);
    assign w_mid_byte = w_in_frame && (r_bit_cnt != I2C_CNT_W'(0));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= ST_IDLE;
            r_sh           <= '0;
            r_bit_cnt      <= '0;
            r_first        <= 1'b0;
            r_rw_bit       <= 1'b0;
            r_addr_match   <= 1'b0;
            r_frame_err    <= 1'b0;
            r_overflow     <= 1'b0;
            r_frame_active <= 1'b0;
        end else begin
            r_state        <= w_state_nxt;
            r_sh           <= w_sh_nxt;
            r_bit_cnt      <= w_bit_cnt_nxt;
            r_first        <= w_first_nxt;
            r_rw_bit       <= w_rw_bit_nxt;
            r_addr_match   <= w_addr_match_nxt;
            r_frame_err    <= w_frame_err_nxt;
            r_overflow     <= w_drop;
            r_frame_active <= (w_state_nxt == ST_ADDR) || (w_state_nxt == ST_DATA);
        end
    end

    // Bus events take priority over bit strobes: bus_err > STOP > START > rd_ld
    always_comb begin
        w_state_nxt      = r_state;
        w_sh_nxt         = r_sh;
        w_bit_cnt_nxt    = r_bit_cnt;
        w_first_nxt      = r_first;
        w_rw_bit_nxt     = r_rw_bit;
        w_addr_match_nxt = 1'b0;
        w_frame_err_nxt  = 1'b0;
        w_push           = 1'b0;

        if (bus_err) begin
            w_state_nxt     = ST_IDLE;
            w_sh_nxt        = '0;
            w_bit_cnt_nxt   = '0;
            w_frame_err_nxt = 1'b1;
        end else if (get_stop) begin
            w_state_nxt     = ST_IDLE;
            w_sh_nxt        = '0;
            w_bit_cnt_nxt   = '0;
            w_frame_err_nxt = w_mid_byte;
        end else if (get_start) begin
            w_state_nxt     = ST_ADDR;
            w_sh_nxt        = '0;
            w_bit_cnt_nxt   = '0;
            w_frame_err_nxt = w_mid_byte;
        end else if (rd_ld && w_in_frame) begin
            w_sh_nxt      = w_byte[SH_W-1:0];
            w_bit_cnt_nxt = r_bit_cnt + I2C_CNT_W'(1);
            if (r_bit_cnt == I2C_CNT_W'(I2C_BYTE_W - 1)) begin
                if (r_state == ST_ADDR) begin
                    if (w_byte[I2C_BYTE_W-1:1] == OWN_ADDR) begin
                        w_addr_match_nxt = 1'b1;
                        w_rw_bit_nxt     = w_byte[0];
                        w_first_nxt      = 1'b1;
                        w_state_nxt      = (w_byte[0] == RW_READ) ? ST_SKIP : ST_DATA;
                    end else begin
                        w_state_nxt = ST_SKIP;
                    end
                end else begin
                    w_push      = 1'b1;
                    w_first_nxt = 1'b0;
                end
            end
        end
    end

    assign w_push_entry = '{first: r_first, data: w_byte};
    assign w_pop        = !w_empty && rx_ready;
    assign w_drop       = w_push && w_full && !w_pop;

    i2c_rx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH ($bits(rx_entry_t))
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .i_push      (w_push),
        .i_push_data (w_push_entry),
        .i_pop       (w_pop),
        .o_head      (w_head),
        .o_full      (w_full),
        .o_empty     (w_empty),
        .o_level     (fifo_level)
    );

    assign rx_data      = w_head.data;
    assign rx_first     = w_head.first;
    assign rx_valid     = !w_empty;
    assign addr_match   = r_addr_match;
    assign rw_bit       = r_rw_bit;
    assign frame_active = r_frame_active;
    assign overflow     = r_overflow;
    assign frame_err    = r_frame_err;

endmodule

// File: tb/tb_i2c_rx_assembler.sv
// Directed bench for i2c_rx_assembler with a scoreboard of expected FIFO output.
module tb_i2c_rx_assembler;

    logic       clk;
    logic       rst;
    logic       rd_ld;
    logic       rd_bit;
    logic       get_start;
    logic       get_stop;
    logic       bus_err;
    logic [7:0] rx_data;
    logic       rx_first;
    logic       rx_valid;
    logic       rx_ready;
    logic       addr_match;
    logic       rw_bit;
    logic       frame_active;
    logic       overflow;
    logic       frame_err;
    logic [2:0] fifo_level;

    int         n_checks = 0;
    int         n_fail   = 0;
    logic [8:0] exp_q[$];
    logic [8:0] mon_e;

    i2c_rx_assembler #(
        .FIFO_DEPTH (4),
        .OWN_ADDR   (7'h50)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .rd_ld        (rd_ld),
        .rd_bit       (rd_bit),
        .get_start    (get_start),
        .get_stop     (get_stop),
        .bus_err      (bus_err),
        .rx_data      (rx_data),
        .rx_first     (rx_first),
        .rx_valid     (rx_valid),
        .rx_ready     (rx_ready),
        .addr_match   (addr_match),
        .rw_bit       (rw_bit),
        .frame_active (frame_active),
        .overflow     (overflow),
        .frame_err    (frame_err),
        .fifo_level   (fifo_level)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Advance past the next rising edge into the drive window
    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic send_bit(input logic b);
        rd_ld  = 1'b1;
        rd_bit = b;
        cyc();
        rd_ld  = 1'b0;
        rd_bit = 1'b0;
    endtask

    task automatic send_bits(input logic [7:0] b, input int n);
        for (int i = 0; i < n; i++) send_bit(b[7-i]);
    endtask

    task automatic send_byte(input logic [7:0] b);
        send_bits(b, 8);
    endtask

    task automatic ev_start();
        get_start = 1'b1;
        cyc();
        get_start = 1'b0;
    endtask

    task automatic ev_stop();
        get_stop = 1'b1;
        cyc();
        get_stop = 1'b0;
    endtask

    task automatic drain(input string tag);
        rx_ready = 1'b1;
        for (int i = 0; i < 40; i++) begin
            if (fifo_level == 3'd0) break;
            cyc();
        end
        chk({tag, "_level"}, 32'(fifo_level), 32'd0);
        chk({tag, "_pending"}, 32'(exp_q.size()), 32'd0);
        rx_ready = 1'b0;
    endtask

    // Scoreboard: every accepted head is compared against the oldest expected entry
    always @(negedge clk) begin
        if (!rst && rx_valid && rx_ready) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $error("FAIL unexpected_pop observed=0x%0h expected=none", {rx_first, rx_data});
            end else begin
                mon_e = exp_q.pop_front();
                chk("rx_head", 32'({rx_first, rx_data}), 32'(mon_e));
            end
        end
    end

    initial begin
        rst = 1'b1; rd_ld = 1'b0; rd_bit = 1'b0; get_start = 1'b0;
        get_stop = 1'b0; bus_err = 1'b0; rx_ready = 1'b0;
        repeat (3) cyc();
        chk("rst_valid", 32'(rx_valid), 32'd0);
        chk("rst_data", 32'({rx_first, rx_data}), 32'd0);
        chk("rst_level", 32'(fifo_level), 32'd0);
        chk("rst_flags", 32'({addr_match, rw_bit, frame_active, overflow, frame_err}), 32'd0);
        rst = 1'b0;
        cyc();

        // Basic write frame with consumer ready
        ev_start();
        chk("t1_active_addr", 32'(frame_active), 32'd1);
        send_byte(8'hA0);
        chk("t1_match", 32'(addr_match), 32'd1);
        chk("t1_rw", 32'(rw_bit), 32'd0);
        rx_ready = 1'b1;
        exp_q.push_back({1'b1, 8'h3C});
        send_byte(8'h3C);
        chk("t1_match_pulse", 32'(addr_match), 32'd0);
        chk("t1_latency_valid", 32'(rx_valid), 32'd1);
        chk("t1_latency_data", 32'({rx_first, rx_data}), 32'h13C);
        exp_q.push_back({1'b0, 8'hC3});
        send_byte(8'hC3);
        chk("t1_active_data", 32'(frame_active), 32'd1);
        ev_stop();
        chk("t1_active_stop", 32'(frame_active), 32'd0);
        chk("t1_no_ferr", 32'(frame_err), 32'd0);
        drain("t1_drain");

        // Master read and foreign address: no data accepted
        ev_start();
        send_byte(8'hA1);
        chk("t2_match", 32'(addr_match), 32'd1);
        chk("t2_rw", 32'(rw_bit), 32'd1);
        chk("t2_active_skip", 32'(frame_active), 32'd0);
        send_byte(8'h55);
        chk("t2_read_level", 32'(fifo_level), 32'd0);
        ev_stop();
        ev_start();
        send_byte(8'hB0);
        chk("t2_nomatch", 32'(addr_match), 32'd0);
        chk("t2_rw_kept", 32'(rw_bit), 32'd1);
        send_byte(8'h66);
        chk("t2_other_level", 32'(fifo_level), 32'd0);
        ev_stop();

        // Overflow with consumer stalled
        rx_ready = 1'b0;
        ev_start();
        send_byte(8'hA0);
        chk("t3_rw_write", 32'(rw_bit), 32'd0);
        for (int k = 1; k <= 5; k++) begin
            if (k <= 4) exp_q.push_back({(k == 1), 8'(k)});
            send_byte(8'(k));
            chk($sformatf("t3_ovf_%0d", k), 32'(overflow), 32'(k == 5));
        end
        chk("t3_level_full", 32'(fifo_level), 32'd4);
        cyc();
        chk("t3_ovf_pulse", 32'(overflow), 32'd0);
        ev_stop();
        drain("t3_drain");

        // Full FIFO, byte completes in the same cycle as a pop
        ev_start();
        send_byte(8'hA0);
        for (int k = 0; k < 4; k++) begin
            exp_q.push_back({(k == 0), 8'(8'h10 + k)});
            send_byte(8'(8'h10 + k));
        end
        chk("t4_level_full", 32'(fifo_level), 32'd4);
        exp_q.push_back({1'b0, 8'h14});
        send_bits(8'h14, 7);
        rd_ld = 1'b1; rd_bit = 1'b0; rx_ready = 1'b1;
        cyc();
        rd_ld = 1'b0; rx_ready = 1'b0;
        chk("t4_level_same", 32'(fifo_level), 32'd4);
        chk("t4_no_ovf", 32'(overflow), 32'd0);
        ev_stop();
        drain("t4_drain");

        // Bus error mid-byte, then STOP mid-byte
        ev_start();
        send_byte(8'hA0);
        exp_q.push_back({1'b1, 8'h11});
        send_byte(8'h11);
        send_bits(8'hE0, 3);
        bus_err = 1'b1;
        cyc();
        bus_err = 1'b0;
        chk("t5_berr_ferr", 32'(frame_err), 32'd1);
        chk("t5_berr_idle", 32'(frame_active), 32'd0);
        chk("t5_berr_kept", 32'(fifo_level), 32'd1);
        send_bits(8'hFF, 8);
        chk("t5_idle_ignored", 32'(fifo_level), 32'd1);
        chk("t5_ferr_pulse", 32'(frame_err), 32'd0);
        ev_start();
        send_byte(8'hA0);
        send_bits(8'hF8, 5);
        ev_stop();
        chk("t5_stop_ferr", 32'(frame_err), 32'd1);
        chk("t5_stop_level", 32'(fifo_level), 32'd1);
        drain("t5_drain");

        // Reset mid-byte discards everything
        ev_start();
        send_byte(8'hA0);
        send_byte(8'h21);
        send_byte(8'h22);
        chk("t6_level_pre", 32'(fifo_level), 32'd2);
        send_bits(8'hA5, 3);
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        chk("t6_valid", 32'(rx_valid), 32'd0);
        chk("t6_level", 32'(fifo_level), 32'd0);
        chk("t6_active", 32'(frame_active), 32'd0);
        chk("t6_data", 32'({rx_first, rx_data}), 32'd0);
        rx_ready = 1'b1;
        ev_start();
        send_byte(8'hA0);
        exp_q.push_back({1'b1, 8'h7E});
        send_byte(8'h7E);
        ev_stop();
        drain("t6_drain");

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
